// File: rtl/prim_sweep_pkg.sv
// prim_sweep_pkg
// Shared definitions for the primitive truth-table sweeper: op indices into
// the six-gate output vector, sweep FSM state type, and the golden function
// producing the expected gate outputs for an input vector.
package prim_sweep_pkg;

  localparam int NUM_OPS = 6;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_XNOR = 3;
  localparam int OP_NAND = 4;
  localparam int OP_NOR  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  // v is zero-extended to 8 bits; only the low n bits take part. Unused
  // bits are forced to 1 for the AND reduction and masked off for OR/XOR.
  function automatic logic [NUM_OPS-1:0] exp_ops(input logic [7:0] v,
                                                 input int unsigned n);
    logic [7:0] m;
    logic       r_and;
    logic       r_or;
    logic       r_xor;
    m     = 8'((9'd1 << n) - 9'd1);
    r_and = &(v | ~m);
    r_or  = |(v & m);
    r_xor = ^(v & m);
    exp_ops = {~r_or, ~r_and, ~r_xor, r_xor, r_or, r_and};
  endfunction

endpackage

// File: rtl/prim_sweep_ref.sv
// prim_sweep_ref
// Golden reference for an N_IN-input gate bank.
// Ports:
//   vec  in   N_IN  input vector
//   exp  out  6     expected outputs {nor, nand, xnor, xor, or, and}
module prim_sweep_ref
  import prim_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0]    vec,
  output logic [NUM_OPS-1:0] exp
);

  assign exp = exp_ops(8'(vec), N_IN);

endmodule

// File: rtl/prim_truth_table_sweeper.sv
// prim_truth_table_sweeper
// Sweeps every N_IN-bit vector into a six-gate primitive bank, compares the
// bank outputs against prim_sweep_ref and reports pass/fail, a saturating
// mismatch count and the first failing vector with its op mask.
// Optional: PRIM_SWEEP_XCHECK_EN makes x/z on a compared dut_y bit count as a
// mismatch and adds the sticky x_seen output.
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      begin a sweep (accepted in IDLE/DONE only)
//   stim       out  N_IN   vector driven to all gates
//   dut_y      in   6      gate outputs {nor, nand, xnor, xor, or, and}
//   busy       out  1      RUN or DRAIN
//   done       out  1      DONE
//   pass       out  1      done and no mismatches
//   err_count  out  CNT_W  mismatch count, saturating
//   fail_vec   out  N_IN   first mismatching vector
//   fail_mask  out  6      mismatching ops of fail_vec
//   x_seen     out  1      (PRIM_SWEEP_XCHECK_EN only) x/z observed
module prim_truth_table_sweeper
  import prim_sweep_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_IN-1:0]    stim,
  input  logic [NUM_OPS-1:0] dut_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [N_IN-1:0]    fail_vec,
  output logic [NUM_OPS-1:0] fail_mask
`ifdef PRIM_SWEEP_XCHECK_EN
  ,
  output logic               x_seen
`endif
);

  localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

  sweep_state_e        state_q;
  logic [N_IN:0]       cnt_q;
  logic [1:0]          drain_q;
  logic                first_fail_q;
  logic [NUM_OPS-1:0]  exp_now;
  logic                run_v;

  logic                d_valid;
  logic [N_IN-1:0]     d_stim;
  logic [NUM_OPS-1:0]  d_exp;
  logic [NUM_OPS-1:0]  mism;
  logic                x_now;
  logic [2:0]          pop;
  logic [CNT_W+2:0]    sum;
  logic [CNT_W-1:0]    err_next;

  assign stim  = cnt_q[N_IN-1:0];
  assign run_v = (state_q == RUN);
  assign busy  = (state_q == RUN) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign pass  = done && (err_count == '0);

  prim_sweep_ref #(.N_IN(N_IN)) u_ref (
    .vec (cnt_q[N_IN-1:0]),
    .exp (exp_now)
  );

  // Expected value travels alongside the bank's own register stages so it
  // meets the matching response; err_count is the compare register stage.
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign d_valid = run_v;
      assign d_stim  = cnt_q[N_IN-1:0];
      assign d_exp   = exp_now;
    end else begin : g_lat
      logic               p_valid [DUT_LAT];
      logic [N_IN-1:0]    p_stim  [DUT_LAT];
      logic [NUM_OPS-1:0] p_exp   [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DUT_LAT; i++) begin
            p_valid[i] <= 1'b0;
            p_stim[i]  <= '0;
            p_exp[i]   <= '0;
          end
        end else begin
          p_valid[0] <= run_v;
          p_stim[0]  <= cnt_q[N_IN-1:0];
          p_exp[0]   <= exp_now;
          for (int i = 1; i < DUT_LAT; i++) begin
            p_valid[i] <= p_valid[i-1];
            p_stim[i]  <= p_stim[i-1];
            p_exp[i]   <= p_exp[i-1];
          end
        end
      end

      assign d_valid = p_valid[DUT_LAT-1];
      assign d_stim  = p_stim[DUT_LAT-1];
      assign d_exp   = p_exp[DUT_LAT-1];
    end
  endgenerate

`ifdef PRIM_SWEEP_XCHECK_EN
  always_comb begin
    mism  = '0;
    x_now = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if ((dut_y[i] !== 1'b0) && (dut_y[i] !== 1'b1)) begin
        mism[i] = 1'b1;
        x_now   = 1'b1;
      end else begin
        mism[i] = d_exp[i] ^ dut_y[i];
      end
    end
  end
`else
  assign mism  = d_exp ^ dut_y;
  assign x_now = 1'b0;
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      pop = pop + {2'b00, mism[i]};
    end
  end

  // Extra headroom bits let the sum overflow CNT_W before saturating.
  assign sum      = (CNT_W+3)'(err_count) + (CNT_W+3)'(pop);
  assign err_next = (sum[CNT_W+2:CNT_W] != 3'b000) ? {CNT_W{1'b1}}
                                                   : sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      first_fail_q <= 1'b0;
      err_count    <= '0;
      fail_vec     <= '0;
      fail_mask    <= '0;
`ifdef PRIM_SWEEP_XCHECK_EN
      x_seen       <= 1'b0;
`endif
    end else begin
      if (d_valid && (mism != '0)) begin
        err_count <= err_next;
        if (!first_fail_q) begin
          fail_vec     <= d_stim;
          fail_mask    <= mism;
          first_fail_q <= 1'b1;
        end
      end
`ifdef PRIM_SWEEP_XCHECK_EN
      if (d_valid && x_now) begin
        x_seen <= 1'b1;
      end
`endif

      // Start clears results after the accumulate above so it always wins.
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            err_count    <= '0;
            fail_vec     <= '0;
            fail_mask    <= '0;
            first_fail_q <= 1'b0;
`ifdef PRIM_SWEEP_XCHECK_EN
            x_seen       <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (cnt_q == LAST_VEC) begin
            if (DUT_LAT > 0) begin
              state_q <= DRAIN;
              drain_q <= 2'(DUT_LAT - 1);
            end else begin
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == 2'd0) begin
            state_q <= DONE;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prim_truth_table_sweeper.sv
// tb_prim_truth_table_sweeper
// Three sweeper instances share clk/rst, each driving a behavioural gate bank
// with a selectable fault:
//   u_a: N_IN=3, DUT_LAT=0, CNT_W=9
//   u_b: N_IN=2, DUT_LAT=2, CNT_W=9
//   u_c: N_IN=2, DUT_LAT=0, CNT_W=2
// Fault modes: 0 ideal, 1 and stuck-at-0, 2 nor inverted, 3 all inverted,
// 4 xor output x at v=5.
module tb_prim_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, start_c;
  int   mode_a, mode_b, mode_c;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] stim_a;
  logic [5:0] y_a;
  logic       busy_a, done_a, pass_a;
  logic [8:0] err_a;
  logic [2:0] fvec_a;
  logic [5:0] fmask_a;
`ifdef PRIM_SWEEP_XCHECK_EN
  logic       xseen_a;
`endif

  logic [1:0] stim_b;
  logic [5:0] yraw_b, y_b1, y_b2;
  logic       busy_b, done_b, pass_b;
  logic [8:0] err_b;
  logic [1:0] fvec_b;
  logic [5:0] fmask_b;

  logic [1:0] stim_c;
  logic [5:0] y_c;
  logic       busy_c, done_c, pass_c;
  logic [1:0] err_c;
  logic [1:0] fvec_c;
  logic [5:0] fmask_c;

  always #5 clk = ~clk;

  function automatic logic [5:0] bank(input logic [7:0] v, input int n,
                                      input int mode);
    logic a, o, x;
    logic [5:0] y;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a & v[i];
      o = o | v[i];
      x = x ^ v[i];
    end
    y = {~o, ~a, ~x, x, o, a};
    case (mode)
      1: y[0] = 1'b0;
      2: y[5] = ~y[5];
      3: y = ~y;
      4: if (v == 8'd5) y[2] = 1'bx;
      default: ;
    endcase
    return y;
  endfunction

  always_comb y_a    = bank({5'd0, stim_a}, 3, mode_a);
  always_comb yraw_b = bank({6'd0, stim_b}, 2, mode_b);
  always_comb y_c    = bank({6'd0, stim_c}, 2, mode_c);

  always_ff @(posedge clk) begin
    y_b1 <= yraw_b;
    y_b2 <= y_b1;
  end

  prim_truth_table_sweeper #(.N_IN(3), .DUT_LAT(0), .CNT_W(9)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_vec(fvec_a), .fail_mask(fmask_a)
`ifdef PRIM_SWEEP_XCHECK_EN
    , .x_seen(xseen_a)
`endif
  );

  prim_truth_table_sweeper #(.N_IN(2), .DUT_LAT(2), .CNT_W(9)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_y(y_b2),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_vec(fvec_b), .fail_mask(fmask_b)
`ifdef PRIM_SWEEP_XCHECK_EN
    , .x_seen()
`endif
  );

  prim_truth_table_sweeper #(.N_IN(2), .DUT_LAT(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .dut_y(y_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .fail_vec(fvec_c), .fail_mask(fmask_c)
`ifdef PRIM_SWEEP_XCHECK_EN
    , .x_seen()
`endif
  );

  function automatic logic done_of(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic set_start(input int which, input logic val);
    case (which)
      0: start_a = val;
      1: start_b = val;
      default: start_c = val;
    endcase
  endtask

  // Pulses start for one edge, then counts edges until done (bounded).
  task automatic run_sweep(input int which, input int exp_lat, input string nm);
    int k;
    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    k = 0;
    while (!done_of(which) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== exp_lat) begin
      errors++;
      $display("FAIL %s latency actual=%0d expected=%0d", nm, k, exp_lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, fvec_a, fmask_a} !== '0) begin
      errors++;
      $display("FAIL reset_a actual=%0h expected=0",
               {stim_a, busy_a, done_a, pass_a, err_a, fvec_a, fmask_a});
    end
    checks++;
    if ({stim_b, busy_b, done_b, pass_b, err_b, fvec_b, fmask_b} !== '0) begin
      errors++;
      $display("FAIL reset_b actual=%0h expected=0",
               {stim_b, busy_b, done_b, pass_b, err_b, fvec_b, fmask_b});
    end
    checks++;
    if ({stim_c, busy_c, done_c, pass_c, err_c, fvec_c, fmask_c} !== '0) begin
      errors++;
      $display("FAIL reset_c actual=%0h expected=0",
               {stim_c, busy_c, done_c, pass_c, err_c, fvec_c, fmask_c});
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    mode_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (stim_a !== 3'(i) || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL ideal_walk actual=stim%0d/busy%0b/done%0b expected=stim%0d/1/0",
                 stim_a, busy_a, done_a, i);
      end
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ideal_done actual=done%0b/pass%0b/busy%0b expected=1/1/0",
               done_a, pass_a, busy_a);
    end
    checks++;
    if (err_a !== 9'd0 || stim_a !== 3'd7) begin
      errors++;
      $display("FAIL ideal_err_stim actual=%0d/%0d expected=0/7", err_a, stim_a);
    end
  endtask

  task automatic test_and_stuck();
    mode_a = 1;
    run_sweep(0, 8, "and_stuck");
    checks++;
    if (err_a !== 9'd1 || fvec_a !== 3'd7 || fmask_a !== 6'b000001 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL and_stuck actual=err%0d/vec%0d/mask%b/pass%0b expected=1/7/000001/0",
               err_a, fvec_a, fmask_a, pass_a);
    end
  endtask

  task automatic test_nor_inv_lat();
    mode_b = 2;
    run_sweep(1, 6, "nor_inv");
    checks++;
    if (err_b !== 9'd4 || fvec_b !== 2'd0 || fmask_b !== 6'b100000 || pass_b !== 1'b0) begin
      errors++;
      $display("FAIL nor_inv actual=err%0d/vec%0d/mask%b/pass%0b expected=4/0/100000/0",
               err_b, fvec_b, fmask_b, pass_b);
    end
    checks++;
    if (stim_b !== 2'd3) begin
      errors++;
      $display("FAIL nor_inv_stim_hold actual=%0d expected=3", stim_b);
    end
  endtask

  task automatic test_saturate();
    mode_c = 3;
    run_sweep(2, 4, "saturate");
    checks++;
    if (err_c !== 2'd3 || fvec_c !== 2'd0 || fmask_c !== 6'b111111 || pass_c !== 1'b0) begin
      errors++;
      $display("FAIL saturate actual=err%0d/vec%0d/mask%b/pass%0b expected=3/0/111111/0",
               err_c, fvec_c, fmask_c, pass_c);
    end
  endtask

  task automatic test_rst_mid();
    int k;
    mode_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (stim_a !== 3'd3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || stim_a !== 3'd0 || err_a !== 9'd0 || fmask_a !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid actual=busy%0b/stim%0d/err%0d/mask%b expected=0/0/0/000000",
               busy_a, stim_a, err_a, fmask_a);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (stim_a !== 3'd3 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored actual=stim%0d/busy%0b expected=3/1", stim_a, busy_a);
    end
    k = 0;
    while (!done_a && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 5 || pass_a !== 1'b1 || err_a !== 9'd0) begin
      errors++;
      $display("FAIL rst_restart actual=lat%0d/pass%0b/err%0d expected=5/1/0",
               k, pass_a, err_a);
    end
  endtask

`ifdef PRIM_SWEEP_XCHECK_EN
  task automatic test_xcheck();
    mode_a = 4;
    run_sweep(0, 8, "xcheck");
    checks++;
    if (xseen_a !== 1'b1 || err_a !== 9'd1 || fvec_a !== 3'd5 || fmask_a !== 6'b000100) begin
      errors++;
      $display("FAIL xcheck actual=x%0b/err%0d/vec%0d/mask%b expected=1/1/5/000100",
               xseen_a, err_a, fvec_a, fmask_a);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 0; mode_b = 0; mode_c = 0;
    test_reset();
    test_ideal();
    test_and_stuck();
    test_nor_inv_lat();
    test_saturate();
    test_rst_mid();
`ifdef PRIM_SWEEP_XCHECK_EN
    test_xcheck();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prim_truth_table_sweeper.md
Name: prim_truth_table_sweeper

Overview:
- Self-checking stimulus/response stage placed around a bank of six N-input gate primitives: and, or, xor, xnor, nand, nor.
- It sits directly upstream, driving a shared input vector into every gate. It also sits directly downstream, consuming the six gate outputs.
- It sweeps all 2^N_IN input combinations, compares each output against an internally computed expected value, and reports pass/fail, error count and the first failing vector.
- Used for gate-level regressions of primitive elaboration.

Parameters:
- N_IN, 3, number of gate inputs swept; legal range 1..8.
- DUT_LAT, 0, number of register stages between stim and dut_y in the gate bank; legal range 0..3.
- CNT_W, 9, width of err_count; saturates at all-ones.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle request to begin a sweep; ignored unless in IDLE or DONE.
- stim  output  N_IN  input vector driven to all six gates.
- dut_y  input  6  gate outputs; bit order [0]=and, [1]=or, [2]=xor, [3]=xnor, [4]=nand, [5]=nor.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  CNT_W  number of (vector, op) mismatches, saturating.
- fail_vec  output  N_IN  stim value of the first mismatching vector.
- fail_mask  output  6  mismatching op bits for fail_vec.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM=IDLE, stim=0, busy=0, done=0, pass=0.
  - err_count=0, fail_vec=0, fail_mask=0.
  - Valid pipeline cleared.
- States:
  - IDLE: waits for start.
  - RUN: drives vectors.
  - DRAIN: waits for the last responses to arrive.
  - DONE: holds results.
- Transitions:
  - IDLE/DONE --start--> RUN. On entry: stim=0, err_count=0, fail_vec=0, fail_mask=0, first-fail flag cleared, done=0.
  - RUN: stim increments by 1 each cycle. After stim reaches 2^N_IN-1, go to DRAIN if DUT_LAT>0, otherwise directly to DONE.
  - DRAIN: lasts exactly DUT_LAT cycles, then DONE.
  - DONE: holds all outputs until start or rst.
- Sweep length: RUN lasts exactly 2^N_IN cycles. Total start-to-done latency is 2^N_IN + DUT_LAT + 1 cycles; done rises on that cycle.
- Expected-value pipeline:
  - Each RUN cycle computes exp[5:0] from stim and sets a valid bit.
  - exp and valid are delayed DUT_LAT cycles, then one compare register stage.
  - Compare occurs only when the delayed valid=1: mism = exp ^ dut_y.
- On mism != 0:
  - err_count += popcount(mism), saturating at 2^CNT_W-1.
  - If the first-fail flag is clear: capture fail_vec (the delayed stim) and fail_mask=mism, then set the flag.
  - Later failures never overwrite fail_vec/fail_mask.
- Expected values for the N_IN-bit vector v:
  - and = &v, or = |v, xor = ^v.
  - xnor = ~^v, nand = ~&v, nor = ~|v.
  - For N_IN=1: and/or/xor = v; xnor/nand/nor = ~v.
- pass = done & (err_count==0). It is combinational from registered state.
- stim holds its last value (2^N_IN-1) during DRAIN and DONE.
- start while busy: ignored; no restart.
- rst mid-sweep: returns to reset values on the next edge; the in-flight pipeline is discarded.
- start and rst in the same cycle: rst wins.
- Wrap-around: the stim counter is N_IN+1 bits internally. The terminal condition is based on the count, not on stim wrap.

Optional Feature:
- Macro: PRIM_SWEEP_XCHECK_EN.
- Defined:
  - Any x/z bit in dut_y on a compared cycle (per bit, dut_y[i] !== 0/1) counts that bit as a mismatch, regardless of exp.
  - An extra output x_seen (1 bit) is sticky-high once any x is observed; it is cleared on start and on rst.
- Undefined:
  - Compare uses plain inequality. X bits follow normal 4-state/2-state semantics of the tool.
  - Port x_seen is absent.

Decomposition:
- Package prim_sweep_pkg:
  - NUM_OPS=6.
  - Op index localparams OP_AND..OP_NOR (0..5).
  - State enum sweep_state_e {IDLE, RUN, DRAIN, DONE}.
  - Function exp_ops(v) returning logic [5:0].
- Sub-module prim_sweep_ref: parameter N_IN, input vector, combinational output exp[5:0]. It is the golden reference, reusable by other primitive benches.

Test Plan:
- Correct ideal bank, N_IN=3, DUT_LAT=0: start at cycle 1. done rises at cycle 10; pass=1, err_count=0, stim walks 0..7.
- and output stuck-at-0, N_IN=3: err_count=1 (only v=7), fail_vec=7, fail_mask=6'b000001, pass=0.
- nor output inverted, N_IN=2, DUT_LAT=2: err_count=4, fail_vec=0, fail_mask=6'b100000; done at 4+2+1=7 cycles after start.
- CNT_W=2, all six outputs inverted, N_IN=2: err_count saturates at 3, fail_mask=6'b111111, fail_vec=0.
- rst asserted during RUN at stim=3, then start: the sweep restarts from stim=0 and the final results match a clean run; start pulsed during RUN is ignored.
- PRIM_SWEEP_XCHECK_EN defined, dut_y[2]=x at v=5: x_seen=1, err_count=1, fail_vec=5, fail_mask=6'b000100.
